// File: rtl/pmem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : pmem_arbiter_rr
// Brief    : Round-robin arbiter granting NUM_PORTS cache ports one line
//            read/write transaction at a time to a single physical memory.
//            Optional macro PMEM_ARB_PERF_EN adds per-port grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module pmem_arbiter_rr #(
    parameter int NUM_PORTS  = 2,
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    localparam int GRANT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic [LINE_WIDTH-1:0]            req_rdata,
    output logic                             pmem_read,
    output logic                             pmem_write,
    output logic [ADDR_WIDTH-1:0]            pmem_address,
    output logic [LINE_WIDTH-1:0]            pmem_wdata,
    input  logic [LINE_WIDTH-1:0]            pmem_rdata,
    input  logic                             pmem_resp,
    output logic [GRANT_W-1:0]               grant_id,
    output logic                             busy
`ifdef PMEM_ARB_PERF_EN
    ,
    output logic [NUM_PORTS*32-1:0]          grant_count
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [GRANT_W-1:0] C_LAST_RST = GRANT_W'(NUM_PORTS - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [GRANT_W-1:0]    r_last_grant;
    logic [GRANT_W-1:0]    r_grant;
    logic [GRANT_W-1:0]    w_winner;
    logic [GRANT_W-1:0]    w_cand;
    logic                  r_op_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [LINE_WIDTH-1:0] r_rdata;
    logic [NUM_PORTS-1:0]  w_req;
    logic                  w_any_req;
    logic                  w_accept;

    logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_PORTS];
    logic [LINE_WIDTH-1:0] w_wdata_arr [NUM_PORTS];

    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
            assign w_addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata_arr[g] = req_wdata[g*LINE_WIDTH +: LINE_WIDTH];
        end
    endgenerate

    assign w_req     = req_read | req_write;
    assign w_any_req = |w_req;
    assign w_accept  = (r_state == S_IDLE) && w_any_req;

    // Scan from the farthest candidate to the nearest so the port closest
    // after last_grant overwrites the others and wins.
    always_comb begin
        w_winner = '0;
        w_cand   = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            w_cand = GRANT_W'((int'(r_last_grant) + i) % NUM_PORTS);
            if (w_req[w_cand]) begin
                w_winner = w_cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_next = S_ISSUE;
            S_ISSUE: if (pmem_resp) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Transaction datapath: everything the memory sees is latched at grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= C_LAST_RST;
            r_op_write   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            if (w_accept) begin
                r_grant    <= w_winner;
                r_op_write <= req_write[w_winner];
                r_addr     <= w_addr_arr[w_winner];
                r_wdata    <= w_wdata_arr[w_winner];
            end
            if ((r_state == S_ISSUE) && pmem_resp && !r_op_write) begin
                r_rdata <= pmem_rdata;
            end
            if (r_state == S_DONE) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Output logic
    always_comb begin
        pmem_read  = (r_state == S_ISSUE) && !r_op_write;
        pmem_write = (r_state == S_ISSUE) && r_op_write;
        busy       = (r_state != S_IDLE);
        req_resp   = '0;
        if (r_state == S_DONE) begin
            req_resp[r_grant] = 1'b1;
        end
    end

    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;
    assign req_rdata    = r_rdata;
    assign grant_id     = r_grant;

`ifdef PMEM_ARB_PERF_EN
    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_perf
            logic [31:0] r_cnt;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (req_resp[g] && (r_cnt != 32'hFFFF_FFFF)) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
            assign grant_count[g*32 +: 32] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmem_arbiter_rr
// Brief    : Directed vector bench for pmem_arbiter_rr with a 4-port instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_arbiter_rr;

    localparam int NP = 4;
    localparam int LW = 256;
    localparam int AW = 32;
    localparam int GW = 2;
    localparam int NV = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    req_read, req_write, req_resp;
    logic [NP*AW-1:0] req_addr;
    logic [NP*LW-1:0] req_wdata;
    logic [LW-1:0]    req_rdata, pmem_wdata, pmem_rdata;
    logic             pmem_read, pmem_write, pmem_resp, busy;
    logic [AW-1:0]    pmem_address;
    logic [GW-1:0]    grant_id;
`ifdef PMEM_ARB_PERF_EN
    logic [NP*32-1:0] grant_count;
`endif

    int            n_cmp = 0;
    int            n_err = 0;
    logic [LW-1:0] model_rdata;
    int            model_cnt [NP];

    always #5 clk = ~clk;

    pmem_arbiter_rr #(
        .NUM_PORTS  (NP),
        .LINE_WIDTH (LW),
        .ADDR_WIDTH (AW)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_read     (req_read),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_resp     (req_resp),
        .req_rdata    (req_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .grant_id     (grant_id),
        .busy         (busy)
`ifdef PMEM_ARB_PERF_EN
        ,
        .grant_count  (grant_count)
`endif
    );

    // mut: 0 = hold inputs, 1 = scramble addr/wdata after grant, 2 = drop requests after grant
    typedef struct {
        logic [NP-1:0]    rd;
        logic [NP-1:0]    wr;
        logic [NP*AW-1:0] addr;
        logic [31:0]      wpat;
        int               lat;
        int               mut;
        logic [7:0]       rbyte;
        int               exp_port;
        logic             exp_wr;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE with requests already applied.
    task automatic run_txn(input int port, input logic wr, input logic [AW-1:0] addr,
                           input logic [LW-1:0] wdata, input int lat, input int mut,
                           input logic [7:0] rbyte);
        @(negedge clk);
        chk("issue_busy", busy, 1);
        chk("grant_id", grant_id, port);
        chk("pmem_read", pmem_read, !wr);
        chk("pmem_write", pmem_write, wr);
        chk("pmem_address", pmem_address, addr);
        if (wr) chk("pmem_wdata", pmem_wdata, wdata);
        chk("issue_resp", req_resp, 0);
        if (mut == 1) begin
            req_addr  = ~req_addr;
            req_wdata = ~req_wdata;
        end else if (mut == 2) begin
            req_read  = '0;
            req_write = '0;
        end
        for (int c = 1; c < lat; c++) begin
            @(negedge clk);
            chk("hold_cmd", {pmem_read, pmem_write}, {!wr, wr});
            chk("hold_addr", pmem_address, addr);
            if (wr) chk("hold_wdata", pmem_wdata, wdata);
        end
        pmem_rdata = {32{rbyte}};
        pmem_resp  = 1'b1;
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        if (!wr) model_rdata = {32{rbyte}};
        model_cnt[port]++;
        chk("done_resp", req_resp, NP'(1) << port);
        chk("done_rdata", req_rdata, model_rdata);
        chk("done_cmd_low", {pmem_read, pmem_write}, 0);
        chk("done_busy", busy, 1);
        @(negedge clk);
        chk("idle_resp", req_resp, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic clear_model();
        model_rdata = '0;
        for (int p = 0; p < NP; p++) model_cnt[p] = 0;
    endtask

    initial begin
        rst        = 1'b1;
        req_read   = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        clear_model();

        // addr fields listed port3..port0; wpat bytes port3..port0
        vecs[0] = '{rd:4'b0001, wr:4'b0000, addr:{32'h0, 32'h0, 32'h0, 32'h100},
                    wpat:32'h0, lat:3, mut:0, rbyte:8'hAA, exp_port:0, exp_wr:1'b0};
        vecs[1] = '{rd:4'b0010, wr:4'b0010, addr:{32'h0, 32'h0, 32'h40, 32'h0},
                    wpat:32'h0000_5500, lat:2, mut:0, rbyte:8'h11, exp_port:1, exp_wr:1'b1};
        vecs[2] = '{rd:4'b1010, wr:4'b0000, addr:{32'h300, 32'h0, 32'h1040, 32'h0},
                    wpat:32'h3300_0000, lat:3, mut:1, rbyte:8'hC3, exp_port:3, exp_wr:1'b0};
        vecs[3] = '{rd:4'b0011, wr:4'b0000, addr:{32'h0, 32'h0, 32'h240, 32'h200},
                    wpat:32'h0, lat:1, mut:0, rbyte:8'h01, exp_port:0, exp_wr:1'b0};
        vecs[4] = '{rd:4'b0011, wr:4'b0000, addr:{32'h0, 32'h0, 32'h240, 32'h200},
                    wpat:32'h0, lat:1, mut:0, rbyte:8'h02, exp_port:1, exp_wr:1'b0};
        vecs[5] = '{rd:4'b0011, wr:4'b0000, addr:{32'h0, 32'h0, 32'h240, 32'h200},
                    wpat:32'h0, lat:1, mut:0, rbyte:8'h03, exp_port:0, exp_wr:1'b0};
        vecs[6] = '{rd:4'b0011, wr:4'b0000, addr:{32'h0, 32'h0, 32'h240, 32'h200},
                    wpat:32'h0, lat:1, mut:0, rbyte:8'h04, exp_port:1, exp_wr:1'b0};
        vecs[7] = '{rd:4'b0100, wr:4'b0001, addr:{32'h0, 32'h600, 32'h0, 32'h500},
                    wpat:32'h0000_005A, lat:2, mut:2, rbyte:8'h66, exp_port:2, exp_wr:1'b0};
        vecs[8] = '{rd:4'b1111, wr:4'b0000, addr:{32'h8C0, 32'h880, 32'h840, 32'h800},
                    wpat:32'h0, lat:2, mut:0, rbyte:8'h77, exp_port:3, exp_wr:1'b0};
        vecs[9] = '{rd:4'b1111, wr:4'b0001, addr:{32'h9C0, 32'h980, 32'h940, 32'h900},
                    wpat:32'h0000_009C, lat:4, mut:0, rbyte:8'h99, exp_port:0, exp_wr:1'b1};

        #1;
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_req_resp", req_resp, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_req_rdata", req_rdata, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Stray memory response while idle must be ignored
        pmem_resp  = 1'b1;
        pmem_rdata = {32{8'hEE}};
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        chk("stray_resp", req_resp, 0);
        chk("stray_busy", busy, 0);
        chk("stray_rdata", req_rdata, 0);

        for (int v = 0; v < NV; v++) begin
            req_read  = vecs[v].rd;
            req_write = vecs[v].wr;
            req_addr  = vecs[v].addr;
            for (int p = 0; p < NP; p++) req_wdata[p*LW +: LW] = {32{vecs[v].wpat[p*8 +: 8]}};
            run_txn(vecs[v].exp_port, vecs[v].exp_wr,
                    vecs[v].addr[vecs[v].exp_port*AW +: AW],
                    {32{vecs[v].wpat[vecs[v].exp_port*8 +: 8]}},
                    vecs[v].lat, vecs[v].mut, vecs[v].rbyte);
        end

        // Reset in the middle of a port-1 read
        req_read  = 4'b0010;
        req_write = '0;
        req_addr  = {32'h0, 32'h0, 32'hA00, 32'hB00};
        req_wdata = '0;
        @(negedge clk);
        chk("pre_rst_read", pmem_read, 1);
        chk("pre_rst_grant", grant_id, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_read", pmem_read, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_grant", grant_id, 0);
        chk("mid_rst_addr", pmem_address, 0);
        chk("mid_rst_rdata", req_rdata, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_no_resp", req_resp, 0);
        end
        clear_model();
        rst      = 1'b0;
        req_read = 4'b0011;
        run_txn(0, 1'b0, 32'hB00, '0, 2, 0, 8'h5C);

        // Five consecutive grants to port 2 from a fresh reset
        req_read = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        req_read = 4'b0100;
        req_addr = {32'h0, 32'hC00, 32'h0, 32'h0};
        for (int k = 0; k < 5; k++) begin
            run_txn(2, 1'b0, 32'hC00, '0, 1 + (k % 3), 0, 8'(8'h20 + k));
        end
        req_read = '0;
`ifdef PMEM_ARB_PERF_EN
        for (int p = 0; p < NP; p++) begin
            chk("grant_count", grant_count[p*32 +: 32], model_cnt[p]);
        end
`endif
        @(negedge clk);
        chk("final_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
